drive_mode_scheduler: RTL and testbench

Clocked controller that sequences the robot's two H-bridge motor outputs from two line sensors and a 3-bit voice command.
- Arbitrates between autonomous line-following and voice-command mode.
- Times voice-command holds.
- Runs a bounded search when the line is lost.
- Inserts dead-time whenever either motor reverses direction.
- Sits between the sensor/voice-decoder front end and the motor driver pins.

---
 rtl/drive_pkg.sv | 50 +++++
 rtl/motor_deadtime.sv | 66 ++++++
 rtl/drive_mode_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_drive_mode_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// -----------------------------------------------------------------------------
// drive_pkg
// Shared encodings for the drive-mode scheduler: FSM state codes, voice command
// codes, motor drive patterns {m1a,m1b,m2a,m2b} and small pattern helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package drive_pkg;

    typedef enum logic [2:0] {
        ST_AUTO    = 3'b000,
        ST_VOICE   = 3'b001,
        ST_STOPPED = 3'b010,
        ST_SEARCH  = 3'b011,
        ST_LOST    = 3'b100
    } state_t;

    localparam logic [2:0] CMD_AUTO  = 3'b000;
    localparam logic [2:0] CMD_FWD   = 3'b001;
    localparam logic [2:0] CMD_RIGHT = 3'b010;
    localparam logic [2:0] CMD_LEFT  = 3'b011;
    localparam logic [2:0] CMD_STOP  = 3'b100;
    localparam logic [2:0] CMD_REV   = 3'b101;

    localparam logic [3:0] PAT_FWD   = 4'b1010;
    localparam logic [3:0] PAT_RIGHT = 4'b1000;
    localparam logic [3:0] PAT_LEFT  = 4'b0010;
    localparam logic [3:0] PAT_STOP  = 4'b0000;
    localparam logic [3:0] PAT_REV   = 4'b0101;
    localparam logic [3:0] PAT_SPIN  = 4'b1001;

    // Motor pattern driven while a voice motion command is latched.
    function automatic logic [3:0] voice_pattern(input logic [2:0] c);
        case (c)
            CMD_FWD:   voice_pattern = PAT_FWD;
            CMD_RIGHT: voice_pattern = PAT_RIGHT;
            CMD_LEFT:  voice_pattern = PAT_LEFT;
            CMD_REV:   voice_pattern = PAT_REV;
            default:   voice_pattern = PAT_STOP;
        endcase
    endfunction

    // Per-motor reversal flags {left, right}: set when a motor driven one way
    // in 'from' is driven the opposite way in 'to'.
    function automatic logic [1:0] reversal_mask(input logic [3:0] from,
                                                 input logic [3:0] to);
        reversal_mask = {(from[3] & to[2]) | (from[2] & to[3]),
                         (from[1] & to[0]) | (from[0] & to[1])};
    endfunction

endpackage

// File: rtl/motor_deadtime.sv
// -----------------------------------------------------------------------------
// motor_deadtime
// Registers the motor drive pattern and inserts an all-off gap of DEAD_CYCLES
// whenever a motor would flip between forward and reverse drive.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   target in   [3:0] requested pattern {m1a,m1b,m2a,m2b}
//   motor  out  [3:0] registered pattern actually driven to the H-bridges
// -----------------------------------------------------------------------------
module motor_deadtime
    import drive_pkg::*;
#(
    parameter int DEAD_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] target,
    output logic [3:0] motor
);

    localparam int            CW        = $clog2(DEAD_CYCLES + 1);
    localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [CW-1:0] dead_cnt;
    logic [3:0]    pre_dead;   // output that was being driven when the gap began
    logic [3:0]    target_p1;  // target as seen on the previous cycle
    logic [1:0]    rev_now;
    logic [1:0]    rev_added;

    assign rev_now   = reversal_mask(motor, target);
    // Only a motor that newly reverses against the pre-gap output restarts the
    // gap; retargeting among already-covered reversals just waits it out.
    assign rev_added = reversal_mask(pre_dead, target) &
                       ~reversal_mask(pre_dead, target_p1);

    // ---- stage p1: target -> driven pattern ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            motor     <= PAT_STOP;
            pre_dead  <= PAT_STOP;
            target_p1 <= PAT_STOP;
            dead_cnt  <= '0;
        end else begin
            target_p1 <= target;
            if (dead_cnt == '0) begin
                if (rev_now != 2'b00) begin
                    motor    <= PAT_STOP;
                    pre_dead <= motor;
                    dead_cnt <= DEAD_LOAD;
                end else begin
                    motor <= target;
                end
            end else if (rev_added != 2'b00) begin
                dead_cnt <= DEAD_LOAD;
            end else if (dead_cnt == CNT_ONE) begin
                motor    <= target;
                dead_cnt <= '0;
            end else begin
                dead_cnt <= dead_cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/drive_mode_scheduler.sv
// -----------------------------------------------------------------------------
// drive_mode_scheduler
// Sequences the two H-bridge motor outputs from two line sensors and a 3-bit
// voice command: line following (AUTO), timed voice moves (VOICE), latched
// stop (STOPPED), bounded spin search (SEARCH) and give-up (LOST).
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   s1, s2           left/right line sensors, asynchronous, 1 = off-line
//   cmd[2:0]         voice command, qualified by the one-cycle cmd_valid strobe
//   m1a,m1b,m2a,m2b  motor drive outputs (left fwd/rev, right fwd/rev)
//   mode_voice       1 while in VOICE or STOPPED
//   state[2:0]       current FSM state code
// -----------------------------------------------------------------------------
module drive_mode_scheduler
    import drive_pkg::*;
#(
    parameter int DEB_CYCLES    = 4,
    parameter int CMD_HOLD      = 1000,
    parameter int SEARCH_CYCLES = 500,
    parameter int DEAD_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s1,
    input  logic       s2,
    input  logic [2:0] cmd,
    input  logic       cmd_valid,
    output logic       m1a,
    output logic       m1b,
    output logic       m2a,
    output logic       m2b,
    output logic       mode_voice,
    output logic [2:0] state
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(CMD_HOLD + 1);
    localparam int SW = $clog2(SEARCH_CYCLES + 1);

    logic [1:0]    sync_p0, sync_p1, seen_p2, filt;
    logic [DW-1:0] run_cnt, run_nxt;

    state_t        cur_state, nxt_state;
    logic [2:0]    vcmd, vcmd_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [SW-1:0] srch_cnt, srch_nxt;
    logic [3:0]    target_p0, target_nxt;
    logic [3:0]    motor;
    logic          cmd_take;

    // run_nxt counts consecutive cycles the synchronised pair has held its
    // value (saturating at DEB_CYCLES); the filter follows once it gets there.
    always_comb begin
        run_nxt = run_cnt;
        if (sync_p1 != seen_p2) begin
            run_nxt = DW'(1);
        end else if (run_cnt < DW'(DEB_CYCLES)) begin
            run_nxt = run_cnt + DW'(1);
        end
    end

    // ---- stages p0/p1: synchroniser, p2: debounce ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 2'b00;
            sync_p1 <= 2'b00;
            seen_p2 <= 2'b00;
            run_cnt <= '0;
            filt    <= 2'b00;
        end else begin
            sync_p0 <= {s1, s2};
            sync_p1 <= sync_p0;
            seen_p2 <= sync_p1;
            run_cnt <= run_nxt;
            if (run_nxt >= DW'(DEB_CYCLES)) begin
                filt <= sync_p1;
            end
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        vcmd_nxt   = vcmd;
        hold_nxt   = hold_cnt;
        srch_nxt   = srch_cnt;
        target_nxt = PAT_STOP;
        cmd_take   = cmd_valid && (cmd != 3'b110) && (cmd != 3'b111);

        // An accepted command wins over anything the current state would do.
        if (cmd_take) begin
            case (cmd)
                CMD_AUTO: nxt_state = ST_AUTO;
                CMD_STOP: nxt_state = ST_STOPPED;
                default: begin
                    nxt_state = ST_VOICE;
                    vcmd_nxt  = cmd;
                    hold_nxt  = HW'(CMD_HOLD);
                end
            endcase
        end else begin
            case (cur_state)
                ST_AUTO: begin
                    if (filt == 2'b11) begin
                        nxt_state = ST_SEARCH;
                        srch_nxt  = SW'(SEARCH_CYCLES);
                    end
                end
                ST_VOICE: begin
                    if (hold_cnt <= HW'(1)) begin
                        nxt_state = ST_AUTO;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt - HW'(1);
                    end
                end
                ST_SEARCH: begin
                    if (filt != 2'b11) begin
                        nxt_state = ST_AUTO;
                    end else if (srch_cnt <= SW'(1)) begin
                        nxt_state = ST_LOST;
                        srch_nxt  = '0;
                    end else begin
                        srch_nxt = srch_cnt - SW'(1);
                    end
                end
                ST_LOST: begin
                    if (filt != 2'b11) begin
                        nxt_state = ST_AUTO;
                    end
                end
                ST_STOPPED: begin
                    nxt_state = ST_STOPPED;
                end
                default: nxt_state = ST_AUTO;
            endcase
        end

        // Pattern for the state being entered; AUTO with both sensors off the
        // line holds still for the one cycle before SEARCH takes over.
        case (nxt_state)
            ST_AUTO: begin
                case (filt)
                    2'b00:   target_nxt = PAT_FWD;
                    2'b10:   target_nxt = PAT_RIGHT;
                    2'b01:   target_nxt = PAT_LEFT;
                    default: target_nxt = PAT_STOP;
                endcase
            end
            ST_VOICE:  target_nxt = voice_pattern(vcmd_nxt);
            ST_SEARCH: target_nxt = PAT_SPIN;
            default:   target_nxt = PAT_STOP;
        endcase
    end

    // ---- stage p0: FSM decision -> state / target registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_AUTO;
            vcmd      <= CMD_AUTO;
            hold_cnt  <= '0;
            srch_cnt  <= '0;
            target_p0 <= PAT_STOP;
        end else begin
            cur_state <= nxt_state;
            vcmd      <= vcmd_nxt;
            hold_cnt  <= hold_nxt;
            srch_cnt  <= srch_nxt;
            target_p0 <= target_nxt;
        end
    end

    motor_deadtime #(
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_deadtime (
        .clk   (clk),
        .rst   (rst),
        .target(target_p0),
        .motor (motor)
    );

    assign {m1a, m1b, m2a, m2b} = motor;
    assign mode_voice           = (cur_state == ST_VOICE) || (cur_state == ST_STOPPED);
    assign state                = cur_state;

endmodule

// File: tb/tb_drive_mode_scheduler.sv
// -----------------------------------------------------------------------------
// tb_drive_mode_scheduler
// Directed scenarios followed by randomized sensor/command traffic, every cycle
// compared against a behavioural model of the scheduler.
// -----------------------------------------------------------------------------
module tb_drive_mode_scheduler;

    localparam int DEB    = 2;
    localparam int HOLD   = 8;
    localparam int SEARCH = 6;
    localparam int DEAD   = 3;

    localparam int M_AUTO = 0, M_VOICE = 1, M_STOPPED = 2, M_SEARCH = 3, M_LOST = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s1 = 1'b0, s2 = 1'b0;
    logic [2:0] cmd = 3'b000;
    logic       cmd_valid = 1'b0;
    logic       m1a, m1b, m2a, m2b, mode_voice;
    logic [2:0] state;

    drive_mode_scheduler #(
        .DEB_CYCLES(DEB), .CMD_HOLD(HOLD), .SEARCH_CYCLES(SEARCH), .DEAD_CYCLES(DEAD)
    ) dut (
        .clk(clk), .rst(rst), .s1(s1), .s2(s2), .cmd(cmd), .cmd_valid(cmd_valid),
        .m1a(m1a), .m1b(m1b), .m2a(m2a), .m2b(m2b),
        .mode_voice(mode_voice), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    bit [1:0] raw_pipe[$];   // raw sensor samples not yet visible past the synchroniser
    bit [1:0] seen_hist[$];  // most recent synchronised samples, oldest first
    bit [1:0] m_filt;
    int       m_mode;
    bit [2:0] m_vcmd;
    int       m_hold_left, m_search_left, m_dead_left;
    bit [3:0] m_tgt, m_out, m_ref, m_tgt_prev;

    // +1 forward, -1 reverse, 0 idle for side 0 (left) / 1 (right)
    function automatic int dir_of(bit [3:0] p, int side);
        bit fa, rb;
        fa = (side == 0) ? p[3] : p[1];
        rb = (side == 0) ? p[2] : p[0];
        return fa ? 1 : (rb ? -1 : 0);
    endfunction

    function automatic bit flips(bit [3:0] a, bit [3:0] b, int side);
        return dir_of(a, side) * dir_of(b, side) < 0;
    endfunction

    function automatic bit [3:0] model_pattern(int mode, bit [2:0] vc, bit [1:0] f);
        bit [3:0] by_cmd [8];
        bit [3:0] by_sens[4];
        by_cmd  = '{4'b0000, 4'b1010, 4'b1000, 4'b0010, 4'b0000, 4'b0101, 4'b0000, 4'b0000};
        by_sens = '{4'b1010, 4'b0010, 4'b1000, 4'b0000};
        if (mode == M_AUTO)   return by_sens[f];
        if (mode == M_VOICE)  return by_cmd[vc];
        if (mode == M_SEARCH) return 4'b1001;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        raw_pipe = '{2'b00, 2'b00};
        seen_hist.delete();
        m_filt = 0; m_mode = M_AUTO; m_vcmd = 0;
        m_hold_left = 0; m_search_left = 0; m_dead_left = 0;
        m_tgt = 0; m_out = 0; m_ref = 0; m_tgt_prev = 0;
    endtask

    task automatic model_step(input bit [1:0] raw, input bit cv, input bit [2:0] c);
        bit [1:0] seen;
        bit       same;
        // motor outputs follow the target chosen on the previous edge
        if (m_dead_left == 0) begin
            if (flips(m_out, m_tgt, 0) || flips(m_out, m_tgt, 1)) begin
                m_ref = m_out; m_out = 0; m_dead_left = DEAD;
            end else begin
                m_out = m_tgt;
            end
        end else if ((flips(m_ref, m_tgt, 0) && !flips(m_ref, m_tgt_prev, 0)) ||
                     (flips(m_ref, m_tgt, 1) && !flips(m_ref, m_tgt_prev, 1))) begin
            m_dead_left = DEAD;
        end else begin
            m_dead_left--;
            if (m_dead_left == 0) m_out = m_tgt;
        end
        m_tgt_prev = m_tgt;
        // mode decision on the filtered pair as it stood before this edge
        if (cv && c <= 3'd5) begin
            if (c == 3'd0)      m_mode = M_AUTO;
            else if (c == 3'd4) m_mode = M_STOPPED;
            else begin m_mode = M_VOICE; m_vcmd = c; m_hold_left = HOLD; end
        end else begin
            case (m_mode)
                M_AUTO: if (m_filt == 2'b11) begin m_mode = M_SEARCH; m_search_left = SEARCH; end
                M_VOICE: begin
                    m_hold_left--;
                    if (m_hold_left == 0) m_mode = M_AUTO;
                end
                M_SEARCH: begin
                    if (m_filt != 2'b11) m_mode = M_AUTO;
                    else begin
                        m_search_left--;
                        if (m_search_left == 0) m_mode = M_LOST;
                    end
                end
                M_LOST: if (m_filt != 2'b11) m_mode = M_AUTO;
                default: ;
            endcase
        end
        m_tgt = model_pattern(m_mode, m_vcmd, m_filt);
        // sensor filter: accept a value once the last DEB synchronised samples agree
        seen = raw_pipe.pop_front();
        raw_pipe.push_back(raw);
        seen_hist.push_back(seen);
        if (seen_hist.size() > DEB) void'(seen_hist.pop_front());
        if (seen_hist.size() == DEB) begin
            same = 1'b1;
            foreach (seen_hist[i]) if (seen_hist[i] != seen) same = 1'b0;
            if (same) m_filt = seen;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic compare_all();
        check("state", 8'(state), 8'(m_mode));
        check("motor", 8'({m1a, m1b, m2a, m2b}), 8'(m_out));
        check("mode_voice", 8'(mode_voice), 8'(m_mode == M_VOICE || m_mode == M_STOPPED));
        check("ab_exclusive", 8'((m1a & m1b) | (m2a & m2b)), 8'd0);
    endtask

    task automatic tick(input bit [1:0] sens, input bit cv, input bit [2:0] c);
        {s1, s2} = sens; cmd_valid = cv; cmd = c;
        @(posedge clk);
        model_step(sens, cv, c);
        #1;
        compare_all();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_motor", 8'({m1a, m1b, m2a, m2b}), 8'd0);
        check("rst_state", 8'(state), 8'd0);
        check("rst_mode_voice", 8'(mode_voice), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit [1:0] sens;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("por_motor", 8'({m1a, m1b, m2a, m2b}), 8'd0);
        check("por_state", 8'(state), 8'd0);
        rst = 1'b0;

        // line centred -> forward; then asynchronous reset mid-run
        repeat (10) tick(2'b00, 0, 0);
        check("fwd_before_rst", 8'({m1a, m1b, m2a, m2b}), 8'b1010);
        do_reset();
        repeat (6) tick(2'b00, 0, 0);
        check("fwd_after_rst", 8'({m1a, m1b, m2a, m2b}), 8'b1010);

        // single-cycle glitch is filtered, held left-off-line turns right
        tick(2'b10, 0, 0);
        repeat (7) tick(2'b00, 0, 0);
        check("glitch_ignored", 8'({m1a, m1b, m2a, m2b}), 8'b1010);
        repeat (8) tick(2'b10, 0, 0);
        check("turn_right", 8'({m1a, m1b, m2a, m2b}), 8'b1000);

        // line lost: search, give up, recover
        repeat (20) tick(2'b11, 0, 0);
        check("lost_state", 8'(state), 8'd4);
        check("lost_motor", 8'({m1a, m1b, m2a, m2b}), 8'd0);
        repeat (8) tick(2'b10, 0, 0);
        check("recover_state", 8'(state), 8'd0);
        check("recover_motor", 8'({m1a, m1b, m2a, m2b}), 8'b1000);

        // reverse voice command from forward, then timeout back to forward
        repeat (8) tick(2'b00, 0, 0);
        tick(2'b00, 1, 3'b101);
        repeat (24) tick(2'b00, 0, 0);
        check("rev_done_motor", 8'({m1a, m1b, m2a, m2b}), 8'b1010);

        // stop holds through sensor activity; reserved command ignored
        tick(2'b00, 1, 3'b100);
        for (int k = 0; k < 12; k++) tick(2'($urandom_range(0, 3)), 0, 0);
        check("stopped_state", 8'(state), 8'd2);
        tick(2'b00, 1, 3'b111);
        repeat (4) tick(2'b00, 0, 0);
        check("reserved_ignored", 8'(state), 8'd2);
        tick(2'b00, 1, 3'b000);
        repeat (8) tick(2'b00, 0, 0);
        check("back_to_auto", 8'(state), 8'd0);

        // command in the very cycle the search expires, then hold restart
        for (int k = 0; k < 40 && !(m_mode == M_SEARCH && m_search_left == 1); k++)
            tick(2'b11, 0, 0);
        check("search_armed", 8'(state), 8'd3);
        tick(2'b11, 1, 3'b001);
        check("cmd_beats_expiry", 8'(state), 8'd1);
        for (int k = 0; k < 20 && m_hold_left != 2; k++) tick(2'b11, 0, 0);
        tick(2'b11, 1, 3'b001);
        repeat (7) tick(2'b11, 0, 0);
        check("hold_restarted", 8'(state), 8'd1);
        tick(2'b11, 0, 0);
        check("hold_expired", 8'(state), 8'd0);

        // randomized traffic
        sens = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            bit [1:0] drive;
            bit       cv;
            bit [2:0] c;
            if ($urandom_range(0, 9) == 0) sens = 2'($urandom_range(0, 3));
            drive = sens;
            if ($urandom_range(0, 24) == 0) drive = 2'($urandom_range(0, 3));
            cv = ($urandom_range(0, 15) == 0);
            c  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 799) == 0) do_reset();
            else tick(drive, cv, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
